// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: shares the single MAC transmit port between N_REQ frame
// sources. A source owns the port for one whole frame, picked round-robin.
// Each frame is followed by an enforced inter-frame gap. Two watchdogs guard
// the port: one for a source that never starts its frame, and one for a MAC
// that never acknowledges the first byte.

module eth_tx_arbiter #(
  parameter int N_REQ       = 2,
  parameter int IFG_CYCLES  = 12,
  parameter int EN_TIMEOUT  = 64,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                 eth_tx_clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     src_req,
  input  logic [8*N_REQ-1:0]   src_data,
  input  logic [N_REQ-1:0]     src_data_en,
  output logic [N_REQ-1:0]     src_grant,
  output logic [N_REQ-1:0]     src_ack,
  output logic [7:0]           eth_tx_data,
  output logic                 eth_tx_data_en,
  input  logic                 eth_tx_ack,
  output logic                 busy,
  output logic                 ack_timeout_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EN,
    XFER,
    GAP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] grant_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic [15:0]      cnt;
  logic [15:0]      cnt_nxt;
  logic             acked;
  logic             acked_nxt;
  logic             err_nxt;

  logic             owner_en;
  logic             owner_req;
  logic [7:0]       owner_data;
  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  // Select the owner's request, enable and byte lane. All of these are zero when nobody holds the grant.
  always_comb begin
    owner_en   = |(grant & src_data_en);
    owner_req  = |(grant & src_req);
    owner_data = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      owner_data = owner_data | (src_data[8*i +: 8] & {8{grant[i]}});
    end
  end

  // Round-robin search starting just after the last granted index. The loop
  // runs from the farthest offset down to the nearest, so the nearest requester
  // is assigned last and wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (src_req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'(idx);
      end
    end
    pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
  end

  // Next-state logic for the frame-ownership FSM, its shared counter and the watchdog abort pulse.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    acked_nxt  = acked;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt  = pick_onehot;
          rr_ptr_nxt = pick_idx;
          cnt_nxt    = 16'd0;
          acked_nxt  = 1'b0;
          state_nxt  = WAIT_EN;
        end
      end
      WAIT_EN: begin
        if (owner_en) begin
          cnt_nxt   = 16'd0;
          state_nxt = XFER;
        end else if (!owner_req || (cnt == 16'(EN_TIMEOUT - 1))) begin
          grant_nxt = '0;
          cnt_nxt   = 16'd0;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      XFER: begin
        if (!owner_en) begin
          grant_nxt = '0;
          cnt_nxt   = 16'd0;
          state_nxt = GAP;
        end else if (!acked) begin
          if (eth_tx_ack) begin
            acked_nxt = 1'b1;
          end else if (cnt == 16'(ACK_TIMEOUT - 1)) begin
            grant_nxt = '0;
            cnt_nxt   = 16'd0;
            err_nxt   = 1'b1;
            state_nxt = GAP;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      GAP: begin
        if (cnt == 16'(IFG_CYCLES - 1)) begin
          cnt_nxt   = 16'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        grant_nxt = '0;
        cnt_nxt   = 16'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, grant, round-robin pointer, counter and error-pulse registers.
  always_ff @(posedge eth_tx_clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      grant           <= '0;
      rr_ptr          <= PTR_W'(N_REQ - 1);
      cnt             <= 16'd0;
      acked           <= 1'b0;
      ack_timeout_err <= 1'b0;
    end else begin
      state           <= state_nxt;
      grant           <= grant_nxt;
      rr_ptr          <= rr_ptr_nxt;
      cnt             <= cnt_nxt;
      acked           <= acked_nxt;
      ack_timeout_err <= err_nxt;
    end
  end

  // Zero-latency datapath from the registered grant. The ack is only forwarded
  // to the owner, and only while the frame is being transferred.
  always_comb begin
    src_grant      = grant;
    eth_tx_data    = owner_data;
    eth_tx_data_en = owner_en & (state == XFER);
    src_ack        = grant & {N_REQ{eth_tx_ack & (state == XFER)}};
    busy           = (state != IDLE);
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed test of eth_tx_arbiter with two sources. The
// bench drives inputs at 1 ns after each rising edge and samples outputs at
// 3 ns after the edge. Byte values, gap lengths and watchdog lengths are
// computed by the bench from the default parameters (IFG 12, EN 64, ACK 1024).

module tb_eth_tx_arbiter;

  logic        eth_tx_clk;
  logic        rst;
  logic [1:0]  src_req;
  logic [15:0] src_data;
  logic [1:0]  src_data_en;
  logic [1:0]  src_grant;
  logic [1:0]  src_ack;
  logic [7:0]  eth_tx_data;
  logic        eth_tx_data_en;
  logic        eth_tx_ack;
  logic        busy;
  logic        ack_timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int err_pulses  = 0;

  eth_tx_arbiter dut (
    .eth_tx_clk      (eth_tx_clk),
    .rst             (rst),
    .src_req         (src_req),
    .src_data        (src_data),
    .src_data_en     (src_data_en),
    .src_grant       (src_grant),
    .src_ack         (src_ack),
    .eth_tx_data     (eth_tx_data),
    .eth_tx_data_en  (eth_tx_data_en),
    .eth_tx_ack      (eth_tx_ack),
    .busy            (busy),
    .ack_timeout_err (ack_timeout_err)
  );

  // 100 MHz transmit clock.
  initial begin
    eth_tx_clk = 1'b0;
    forever #5 eth_tx_clk = ~eth_tx_clk;
  end

  // Count every abort pulse so that tests can check how many occurred.
  always @(negedge eth_tx_clk) begin
    if (ack_timeout_err === 1'b1) err_pulses++;
  end

  // Safety net: the bench must never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit expired");
  end

  // One comparison: count it, and report and count it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Byte i of the frame that source s sends.
  function automatic logic [7:0] byteOf(input int s, input int i);
    return 8'((i * 13 + 7 + s * 101) % 256);
  endfunction

  // Advance to the drive point of the next cycle.
  task automatic nextCycle();
    @(posedge eth_tx_clk);
    #1;
  endtask

  // Drive one source's byte lane.
  task automatic setLane(input int s, input logic [7:0] b);
    src_data[8*s +: 8] = b;
  endtask

  // Wait for any grant to appear. The wait is bounded; waited returns the
  // number of cycles with no grant.
  task automatic waitGrant(output int waited, output bit granted);
    waited  = 0;
    granted = 1'b0;
    for (int w = 0; w < 300; w++) begin
      nextCycle();
      if (src_grant !== 2'b00) begin
        granted = 1'b1;
        break;
      end
      waited++;
    end
    checkOutput("grant_seen", 32'(granted), 32'd1);
  endtask

  // Serve one frame of source s with src_req[s] already high. The MAC acks in
  // XFER cycle ack_at (cycle 0 is the first cycle with eth_tx_data_en high).
  // The source holds byte 0 until that ack and then streams one byte per
  // cycle. After the frame, the 12 gap cycles are checked. If rereq is set,
  // the source requests again in the first gap cycle. If rst_byte is 0 or
  // more, reset is asserted while that byte is on the bus.
  task automatic applyStimulus(input int s, input int nbytes, input int ack_at, input bit rereq,
                               input int rst_byte, output int waited);
    logic [1:0] oh;
    bit         granted;
    bit         done;
    int         idx;
    oh      = 2'b00;
    oh[s]   = 1'b1;
    done    = 1'b0;
    waitGrant(waited, granted);
    if (!granted) return;
    checkOutput($sformatf("grant_owner_src%0d", s), 32'(src_grant), 32'(oh));
    src_data_en[s] = 1'b1;
    setLane(s, byteOf(s, 0));
    #2;
    checkOutput("wait_en_mac_en_low", 32'(eth_tx_data_en), 32'd0);
    checkOutput("wait_en_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4000; k++) begin
      nextCycle();
      eth_tx_ack = (k == ack_at);
      idx = (k > ack_at) ? (k - ack_at) : 0;
      if (idx < nbytes) begin
        setLane(s, byteOf(s, idx));
      end else begin
        src_data_en[s] = 1'b0;
        src_req[s]     = 1'b0;
      end
      #2;
      if (idx >= nbytes) begin
        checkOutput("frame_end_en_low", 32'(eth_tx_data_en), 32'd0);
        done = 1'b1;
        break;
      end
      checkOutput("xfer_en", 32'(eth_tx_data_en), 32'd1);
      checkOutput($sformatf("xfer_byte_%0d", idx), 32'(eth_tx_data), 32'(byteOf(s, idx)));
      checkOutput("xfer_src_ack", 32'(src_ack), (k == ack_at) ? 32'(oh) : 32'd0);
      if ((rst_byte >= 0) && (k > ack_at) && (idx == rst_byte)) begin
        rst = 1'b1;
        #1;
        checkOutput("rst_en_async", 32'(eth_tx_data_en), 32'd0);
        checkOutput("rst_grant", 32'(src_grant), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_data", 32'(eth_tx_data), 32'd0);
        src_data_en = 2'b00;
        src_req     = 2'b00;
        eth_tx_ack  = 1'b0;
        return;
      end
    end
    checkOutput("frame_end_seen", 32'(done), 32'd1);
    for (int g = 1; g <= 12; g++) begin
      nextCycle();
      eth_tx_ack = 1'b0;
      if (rereq && (g == 1)) src_req[s] = 1'b1;
      #2;
      checkOutput($sformatf("gap%0d_grant", g), 32'(src_grant), 32'd0);
      checkOutput($sformatf("gap%0d_en", g), 32'(eth_tx_data_en), 32'd0);
      checkOutput($sformatf("gap%0d_busy", g), 32'(busy), 32'd1);
    end
  endtask

  // Directed sequence: reset, single frame, contention, enable watchdog, ack watchdog, late ack, reset mid-frame.
  initial begin
    int  waited;
    int  err_base;
    int  hi_count;
    bit  granted;
    bit  abort_seen;

    rst         = 1'b1;
    src_req     = 2'b00;
    src_data    = 16'h5A5A;
    src_data_en = 2'b00;
    eth_tx_ack  = 1'b0;

    // Check the outputs while reset is held.
    #2;
    checkOutput("reset_grant", 32'(src_grant), 32'd0);
    checkOutput("reset_ack", 32'(src_ack), 32'd0);
    checkOutput("reset_data", 32'(eth_tx_data), 32'd0);
    checkOutput("reset_en", 32'(eth_tx_data_en), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_err", 32'(ack_timeout_err), 32'd0);
    nextCycle();
    nextCycle();
    rst = 1'b0;

    // An ack while nobody holds the grant is not forwarded and does not change the state.
    nextCycle();
    eth_tx_ack = 1'b1;
    #2;
    checkOutput("idle_ack_not_forwarded", 32'(src_ack), 32'd0);
    nextCycle();
    eth_tx_ack = 1'b0;
    #2;
    checkOutput("idle_ack_ignored_busy", 32'(busy), 32'd0);

    // Test 1: source 1 sends a 42-byte frame, and the MAC acks 6 cycles after en rises.
    err_base = err_pulses;
    src_req[1] = 1'b1;
    applyStimulus(1, 42, 6, 1'b0, -1, waited);
    checkOutput("t1_grant_latency", 32'(waited), 32'd0);
    nextCycle();
    #2;
    checkOutput("t1_back_to_idle", 32'(busy), 32'd0);

    // Test 2: both sources request, and both request again after each frame. Expected order 0,1,0,1.
    src_req = 2'b11;
    applyStimulus(0, 8, 2, 1'b1, -1, waited);
    checkOutput("t2_f0_latency", 32'(waited), 32'd0);
    applyStimulus(1, 8, 2, 1'b1, -1, waited);
    checkOutput("t2_f1_after_gap", 32'(waited), 32'd1);
    applyStimulus(0, 8, 2, 1'b1, -1, waited);
    checkOutput("t2_f2_after_gap", 32'(waited), 32'd1);
    applyStimulus(1, 8, 2, 1'b1, -1, waited);
    checkOutput("t2_f3_after_gap", 32'(waited), 32'd1);

    // Test 3: source 0 is granted next but never raises en. The grant is revoked after 64 cycles.
    // Source 1's en during this time must be ignored.
    waitGrant(waited, granted);
    checkOutput("t3_owner_src0", 32'(src_grant), 32'd1);
    for (int k = 1; k <= 64; k++) begin
      nextCycle();
      src_data_en[1] = (k == 10);
      if (k == 64) src_req[0] = 1'b0;
      #2;
      if (k < 64) begin
        checkOutput($sformatf("t3_hold_%0d", k), 32'(src_grant), 32'd1);
        checkOutput($sformatf("t3_en_low_%0d", k), 32'(eth_tx_data_en), 32'd0);
      end else begin
        checkOutput("t3_revoked", 32'(src_grant), 32'd0);
        checkOutput("t3_revoked_busy", 32'(busy), 32'd1);
        checkOutput("t3_no_err", 32'(ack_timeout_err), 32'd0);
      end
    end
    src_data_en[1] = 1'b0;
    applyStimulus(1, 8, 2, 1'b0, -1, waited);
    checkOutput("t3_other_served_wait", 32'(waited), 32'd12);
    checkOutput("t3_err_count", 32'(err_pulses - err_base), 32'd0);

    // Test 4: the MAC never acks. en must stay high for 1024 cycles, and then
    // the frame is aborted with one error pulse.
    err_base = err_pulses;
    src_req[0] = 1'b1;
    waitGrant(waited, granted);
    checkOutput("t4_owner_src0", 32'(src_grant), 32'd1);
    src_data_en[0] = 1'b1;
    setLane(0, 8'hC3);
    hi_count   = 0;
    abort_seen = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      nextCycle();
      if (src_grant === 2'b00) begin
        src_data_en[0] = 1'b0;
        src_req[0]     = 1'b0;
      end
      #2;
      if (eth_tx_data_en === 1'b1) begin
        hi_count++;
      end else begin
        abort_seen = 1'b1;
        break;
      end
    end
    checkOutput("t4_abort_seen", 32'(abort_seen), 32'd1);
    checkOutput("t4_en_high_cycles", 32'(hi_count), 32'd1024);
    checkOutput("t4_err_pulse", 32'(ack_timeout_err), 32'd1);
    checkOutput("t4_grant_dropped", 32'(src_grant), 32'd0);
    checkOutput("t4_in_gap", 32'(busy), 32'd1);
    src_data_en[0] = 1'b0;
    src_req[0]     = 1'b0;
    nextCycle();
    #2;
    checkOutput("t4_err_one_cycle", 32'(ack_timeout_err), 32'd0);
    nextCycle();
    checkOutput("t4_err_count", 32'(err_pulses - err_base), 32'd1);

    // Test 5: the ack arrives exactly on watchdog cycle 1023. This must not abort the frame.
    err_base = err_pulses;
    src_req[1] = 1'b1;
    applyStimulus(1, 4, 1023, 1'b0, -1, waited);
    checkOutput("t5_err_count", 32'(err_pulses - err_base), 32'd0);

    // Test 6: reset is pulsed while byte 20 is on the bus. After release, a new frame must go through.
    src_req[0] = 1'b1;
    applyStimulus(0, 42, 3, 1'b0, 20, waited);
    nextCycle();
    #2;
    checkOutput("t6_held_grant", 32'(src_grant), 32'd0);
    checkOutput("t6_held_en", 32'(eth_tx_data_en), 32'd0);
    nextCycle();
    rst        = 1'b0;
    src_req[0] = 1'b1;
    applyStimulus(0, 6, 1, 1'b0, -1, waited);
    checkOutput("t6_regrant_latency", 32'(waited), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
